// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions: pipeline stage indices, the per-stage vector type and
// the flush sequencer state encoding.
package cpu_defs;

   localparam int STG_IF = 0;
   localparam int STG_ID = 1;
   localparam int STG_EX = 2;
   localparam int STG_MM = 3;
   localparam int STG_WB = 4;

   typedef logic [4:0] stage_vec_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } pipe_ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/flush bundle between the pipeline stages and the stall/flush sequencer.
interface pipe_ctrl_if;
   import cpu_defs::*;

   logic        icache_busy_i;
   logic        stall_id_i;
   logic        dcache_busy_i;
   logic        mdu_start_i;
   logic        mdu_is_div_i;
   logic        flush_req_i;
   logic [31:0] flush_pc_i;
   stage_vec_t  stall_o;
   stage_vec_t  bubble_o;
   stage_vec_t  flush_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        mdu_done_o;

   // Pipeline side: raises requests, consumes the control vectors.
   modport master (
      output icache_busy_i, stall_id_i, dcache_busy_i, mdu_start_i, mdu_is_div_i,
             flush_req_i, flush_pc_i,
      input  stall_o, bubble_o, flush_o, redirect_valid_o, redirect_pc_o, mdu_done_o
   );

   // Sequencer side.
   modport slave (
      input  icache_busy_i, stall_id_i, dcache_busy_i, mdu_start_i, mdu_is_div_i,
             flush_req_i, flush_pc_i,
      output stall_o, bubble_o, flush_o, redirect_valid_o, redirect_pc_o, mdu_done_o
   );

endinterface

// File: rtl/pipe_ctrl_mdu_counter.sv
// MDU occupancy counter: holds EX for the full multiply/divide latency and flags
// the final cycle; a clear discards any operation in flight.
module mdu_counter #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 36
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   input  logic i_is_div,
   input  logic i_clr,
   output logic o_busy,
   output logic o_done
);

   localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

   logic [5:0] r_cnt;
   logic [5:0] w_cnt_next;
   logic       w_idle;

   assign w_idle = (r_cnt == 6'd0);

   // A running count always runs out, even under downstream stalls; starts while busy are ignored.
   always_comb begin
      w_cnt_next = r_cnt;
      if (i_clr)
         w_cnt_next = 6'd0;
      else if (!w_idle)
         w_cnt_next = r_cnt - 6'd1;
      else if (i_start)
         w_cnt_next = i_is_div ? DIV_LAST : MUL_LAST;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= 6'd0;
      else
         r_cnt <= w_cnt_next;
   end

   assign o_busy = (i_start & w_idle) | (r_cnt > 6'd1);
   assign o_done = (r_cnt == 6'd1);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/bubble/flush sequencer for the five-stage core, including the deferred
// PC redirect while an instruction fetch is still outstanding.
module pipe_ctrl
   import cpu_defs::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 36
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_ctrl_if.slave  bus
);

   pipe_ctrl_state_t r_state;
   logic [31:0]      r_pc;

   logic        w_drain;
   logic        w_flush_acc;
   logic        w_mdu_busy;
   logic        w_mdu_done;
   stage_vec_t  w_raw;
   stage_vec_t  w_stall;
   stage_vec_t  w_bubble;
   stage_vec_t  w_flush;
   logic        w_redir_valid;
   logic [31:0] w_redir_pc;

   assign w_drain     = (r_state == DRAIN);
   assign w_flush_acc = bus.flush_req_i & ~bus.dcache_busy_i;

   mdu_counter #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdu_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (bus.mdu_start_i),
      .i_is_div (bus.mdu_is_div_i),
      .i_clr    (w_flush_acc),
      .o_busy   (w_mdu_busy),
      .o_done   (w_mdu_done)
   );

   assign w_raw[STG_IF] = bus.icache_busy_i | w_drain;
   assign w_raw[STG_ID] = bus.stall_id_i;
   assign w_raw[STG_EX] = w_mdu_busy;
   assign w_raw[STG_MM] = bus.dcache_busy_i;
   assign w_raw[STG_WB] = 1'b0;

   // A stage holds whenever it or any later stage holds; a bubble enters where a hold ends.
   assign w_bubble[STG_IF] = 1'b0;
   for (genvar gi = STG_IF; gi <= STG_WB; gi++) begin : g_stall
      assign w_stall[gi] = |w_raw[STG_WB:gi];
   end
   for (genvar gi = STG_IF; gi < STG_WB; gi++) begin : g_bubble
      assign w_bubble[gi+1] = w_stall[gi] & ~w_stall[gi+1];
   end

   always_comb begin
      w_flush = 5'b00000;
      if (w_flush_acc)
         w_flush = 5'b01111;
      else if (w_drain)
         w_flush = 5'b00011;
   end

   // A flush arriving in the leaving cycle of DRAIN supersedes the latched target.
   always_comb begin
      w_redir_valid = 1'b0;
      w_redir_pc    = 32'h0;
      if (!bus.icache_busy_i) begin
         if (w_flush_acc) begin
            w_redir_valid = 1'b1;
            w_redir_pc    = bus.flush_pc_i;
         end else if (w_drain) begin
            w_redir_valid = 1'b1;
            w_redir_pc    = r_pc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_pc    <= 32'h0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_flush_acc && bus.icache_busy_i) begin
                  r_pc    <= bus.flush_pc_i;
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_flush_acc)
                  r_pc <= bus.flush_pc_i;
               if (!bus.icache_busy_i)
                  r_state <= RUN;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign bus.stall_o          = w_stall;
   assign bus.bubble_o         = w_bubble;
   assign bus.flush_o          = w_flush;
   assign bus.redirect_valid_o = w_redir_valid;
   assign bus.redirect_pc_o    = w_redir_pc;
   assign bus.mdu_done_o       = w_mdu_done;

endmodule
